// File: rtl/uhci_sched_pkg.sv
// Shared types and constants for the UHCI multi-channel transfer scheduler.
package uhci_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SOF    = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_REPORT = 3'd4
   } sched_state_e;

   localparam logic [2:0] ST_ACK        = 3'd0;
   localparam logic [2:0] ST_NAK        = 3'd1;
   localparam logic [2:0] ST_STALL      = 3'd2;
   localparam logic [2:0] ST_ERR        = 3'd3;
   localparam logic [2:0] ST_TOGGLE_ERR = 3'd4;

   localparam int PID_W   = 8;
   localparam int ADDR_W  = 7;
   localparam int EP_W    = 4;
   localparam int FRAME_W = 11;

   // Width of a channel index; a single-bit index is kept even for tiny counts.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uhci_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr+1 (mod N_CH) and returns it both one-hot and as an index.
module uhci_rr_arbiter
   import uhci_sched_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int IDX_W = idx_w(N_CH)
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_CH-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   logic found;
   int   c;

   // Scan channels starting just past the last winner.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      c     = 0;
      for (int i = 1; i <= N_CH; i++) begin
         c = (int'(ptr_i) + i) % N_CH;
         if (!found && req_i[c]) begin
            found    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/uhci_xfer_sched.sv
// UHCI transfer scheduler: round-robin over N_CH transfer channels, frame
// timer with SOF issue, retry of CRC/timeout errors, one-hot completion.
// Optional build macro UHCI_SCHED_STATS_EN adds per-channel retry counters.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | waiting; SOF first, otherwise grant a channel outside guard
//  S_SOF    | sof_req held until SIE reports sof_done
//  S_ISSUE  | token presented to SIE until tok_ready
//  S_WAIT   | waiting for handshake or error report
//  S_REPORT | one-cycle completion pulse for the latched channel
module uhci_xfer_sched
   import uhci_sched_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int MAX_RETRY    = 3,
   parameter int FRAME_CYCLES = 12000,
   parameter int GUARD_CYCLES = 600,
   parameter int CNT_W        = $clog2(FRAME_CYCLES)
) (
   input  logic                 UHCI_clk,
   input  logic                 rst_n,
   input  logic                 frame_en,
   input  logic [N_CH-1:0]      req_valid,
   input  logic [N_CH*8-1:0]    req_pid,
   input  logic [N_CH*7-1:0]    req_addr,
   input  logic [N_CH*4-1:0]    req_ep,
   input  logic [N_CH-1:0]      req_toggle,
   output logic [N_CH-1:0]      req_ready,
   output logic [N_CH-1:0]      done_valid,
   output logic [2:0]           done_status,
   output logic [2:0]           done_retries,
   output logic                 tok_valid,
   output logic [7:0]           tok_pid,
   output logic [6:0]           tok_addr,
   output logic [3:0]           tok_ep,
   output logic                 tok_toggle,
   input  logic                 tok_ready,
   output logic                 sof_req,
   output logic [10:0]          frame_num,
   input  logic                 sof_done,
   input  logic                 hs_ready,
   input  logic                 nak_i,
   input  logic                 stall_i,
   input  logic                 errs_ready,
   input  logic                 crc_err,
   input  logic                 timeout_err,
   input  logic                 toggle_err,
   output logic [N_CH*8-1:0]    stat_retries
);

   localparam int IDX_W      = idx_w(N_CH);
   localparam int OPEN_LIMIT = FRAME_CYCLES - GUARD_CYCLES;

   sched_state_e         state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 sof_pend_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [IDX_W-1:0]     ptr_q;
   logic [IDX_W-1:0]     ch_q;
   logic [PID_W-1:0]     pid_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [EP_W-1:0]      ep_q;
   logic                 toggle_q;
   logic [2:0]           retry_q, retry_d;
   logic [2:0]           status_q, status_d;
   logic                 run_q;

   logic [N_CH-1:0]      arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 grant_fire;
   logic                 sof_clr;
   logic                 wrap;
   logic                 in_window;

   // crc_err and timeout_err both select the retry path, which is also the
   // path for an unqualified error strobe, so they carry no extra decode.
   logic unused_err_kind;
   assign unused_err_kind = crc_err | timeout_err;

   uhci_rr_arbiter #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign wrap      = (cnt_q == CNT_W'(FRAME_CYCLES - 1));
   assign in_window = (int'(cnt_q) < OPEN_LIMIT);

   // Frame timer and pending-SOF flag; a wrap in the same cycle as an SOF
   // completion keeps the new SOF pending.
   always_ff @(posedge UHCI_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         sof_pend_q <= 1'b0;
      end else if (!frame_en) begin
         cnt_q      <= '0;
         sof_pend_q <= 1'b0;
      end else begin
         cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
         if (wrap) begin
            sof_pend_q <= 1'b1;
         end else if (sof_clr) begin
            sof_pend_q <= 1'b0;
         end
      end
   end

   // FSM state, transfer context and frame number registers.
   always_ff @(posedge UHCI_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         run_q    <= 1'b0;
         frame_q  <= '0;
         ptr_q    <= '0;
         ch_q     <= '0;
         pid_q    <= '0;
         addr_q   <= '0;
         ep_q     <= '0;
         toggle_q <= 1'b0;
         retry_q  <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         retry_q  <= retry_d;
         status_q <= status_d;
         if (sof_clr) begin
            frame_q <= frame_q + FRAME_W'(1);
         end
         if (grant_fire) begin
            ptr_q    <= arb_idx;
            ch_q     <= arb_idx;
            pid_q    <= req_pid[arb_idx*PID_W +: PID_W];
            addr_q   <= req_addr[arb_idx*ADDR_W +: ADDR_W];
            ep_q     <= req_ep[arb_idx*EP_W +: EP_W];
            toggle_q <= req_toggle[arb_idx];
         end
      end
   end

   // Next-state and handshake outputs; run_q keeps grants off until the
   // first clock after reset release.
   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      status_d     = status_q;
      grant_fire   = 1'b0;
      sof_clr      = 1'b0;
      req_ready    = '0;
      done_valid   = '0;
      done_status  = '0;
      done_retries = '0;
      tok_valid    = 1'b0;
      sof_req      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sof_pend_q) begin
               state_d = S_SOF;
            end else if (run_q && (|req_valid) && in_window) begin
               grant_fire = 1'b1;
               req_ready  = arb_gnt;
               retry_d    = '0;
               status_d   = ST_ACK;
               state_d    = S_ISSUE;
            end
         end
         S_SOF: begin
            sof_req = 1'b1;
            if (sof_done) begin
               sof_clr = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            tok_valid = 1'b1;
            if (tok_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (errs_ready) begin
               if (toggle_err) begin
                  status_d = ST_TOGGLE_ERR;
                  state_d  = S_REPORT;
               end else if (retry_q < 3'(MAX_RETRY)) begin
                  retry_d = retry_q + 3'd1;
                  state_d = S_ISSUE;
               end else begin
                  status_d = ST_ERR;
                  state_d  = S_REPORT;
               end
            end else if (hs_ready) begin
               if (stall_i) begin
                  status_d = ST_STALL;
               end else if (nak_i) begin
                  status_d = ST_NAK;
               end else begin
                  status_d = ST_ACK;
               end
               state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            done_valid[ch_q] = 1'b1;
            done_status      = status_q;
            done_retries     = retry_q;
            state_d          = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign tok_pid    = pid_q;
   assign tok_addr   = addr_q;
   assign tok_ep     = ep_q;
   assign tok_toggle = toggle_q;
   assign frame_num  = frame_q;

`ifdef UHCI_SCHED_STATS_EN
   logic [N_CH-1:0][7:0] stat_q;
   logic                 retry_evt;

   assign retry_evt = (state_q == S_WAIT) && (state_d == S_ISSUE);

   // Saturating per-channel retry counters.
   always_ff @(posedge UHCI_clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else if (retry_evt && (stat_q[ch_q] != 8'hFF)) begin
         stat_q[ch_q] <= stat_q[ch_q] + 8'd1;
      end
   end

   assign stat_retries = stat_q;
`else
   assign stat_retries = '0;
`endif

endmodule

// File: tb/tb_uhci_xfer_sched.sv
// Directed bench for uhci_xfer_sched: arbitration order, handshake/error
// outcomes and retries, reset mid-transfer, guard window, SOF and frame wrap.
module tb_uhci_xfer_sched;

   localparam int N_CH         = 4;
   localparam int MAX_RETRY    = 3;
   localparam int FRAME_CYCLES = 20;
   localparam int GUARD_CYCLES = 4;

   logic              UHCI_clk = 1'b0;
   logic              rst_n;
   logic              frame_en;
   logic [N_CH-1:0]   req_valid;
   logic [N_CH*8-1:0] req_pid;
   logic [N_CH*7-1:0] req_addr;
   logic [N_CH*4-1:0] req_ep;
   logic [N_CH-1:0]   req_toggle;
   logic [N_CH-1:0]   req_ready;
   logic [N_CH-1:0]   done_valid;
   logic [2:0]        done_status;
   logic [2:0]        done_retries;
   logic              tok_valid;
   logic [7:0]        tok_pid;
   logic [6:0]        tok_addr;
   logic [3:0]        tok_ep;
   logic              tok_toggle;
   logic              tok_ready;
   logic              sof_req;
   logic [10:0]       frame_num;
   logic              sof_done;
   logic              hs_ready;
   logic              nak_i;
   logic              stall_i;
   logic              errs_ready;
   logic              crc_err;
   logic              timeout_err;
   logic              toggle_err;
   logic [N_CH*8-1:0] stat_retries;

   int n_chk = 0;
   int n_err = 0;
   int n_tok = 0;

   always #5 UHCI_clk = ~UHCI_clk;

   uhci_xfer_sched #(
      .N_CH         (N_CH),
      .MAX_RETRY    (MAX_RETRY),
      .FRAME_CYCLES (FRAME_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) dut (
      .UHCI_clk     (UHCI_clk),
      .rst_n        (rst_n),
      .frame_en     (frame_en),
      .req_valid    (req_valid),
      .req_pid      (req_pid),
      .req_addr     (req_addr),
      .req_ep       (req_ep),
      .req_toggle   (req_toggle),
      .req_ready    (req_ready),
      .done_valid   (done_valid),
      .done_status  (done_status),
      .done_retries (done_retries),
      .tok_valid    (tok_valid),
      .tok_pid      (tok_pid),
      .tok_addr     (tok_addr),
      .tok_ep       (tok_ep),
      .tok_toggle   (tok_toggle),
      .tok_ready    (tok_ready),
      .sof_req      (sof_req),
      .frame_num    (frame_num),
      .sof_done     (sof_done),
      .hs_ready     (hs_ready),
      .nak_i        (nak_i),
      .stall_i      (stall_i),
      .errs_ready   (errs_ready),
      .crc_err      (crc_err),
      .timeout_err  (timeout_err),
      .toggle_err   (toggle_err),
      .stat_retries (stat_retries)
   );

   function automatic logic [7:0] pid_of(input int ch);
      return 8'h10 + 8'(ch) * 8'h11;
   endfunction
   function automatic logic [6:0] addr_of(input int ch);
      return 7'h20 + 7'(ch);
   endfunction
   function automatic logic [3:0] ep_of(input int ch);
      return 4'(ch + 1);
   endfunction
   function automatic logic tgl_of(input int ch);
      return ch[0];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge UHCI_clk);
      #2;
   endtask

   // Wait (bounded) for a grant pulse, check it, then drop the granted request.
   task automatic wait_grant(input string tag, input logic [N_CH-1:0] exp_g);
      logic [N_CH-1:0] g;
      g = '0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (req_ready != '0) begin
            g = req_ready;
            break;
         end
         step();
      end
      check_eq(tag, 32'(g), 32'(exp_g));
      step();
      req_valid = req_valid & ~exp_g;
   endtask

   task automatic tok_phase(input string tag, input int ch);
      #1;
      check_eq({tag, "_tv"}, 32'(tok_valid), 1);
      if (tok_valid) n_tok++;
      check_eq({tag, "_pid"}, 32'(tok_pid), 32'(pid_of(ch)));
      check_eq({tag, "_addr"}, 32'(tok_addr), 32'(addr_of(ch)));
      check_eq({tag, "_ep"}, 32'(tok_ep), 32'(ep_of(ch)));
      check_eq({tag, "_tgl"}, 32'(tok_toggle), 32'(tgl_of(ch)));
      tok_ready = 1'b1;
      step();
      tok_ready = 1'b0;
      #1;
      check_eq({tag, "_tdrop"}, 32'(tok_valid), 0);
   endtask

   task automatic respond(input logic hs, input logic nak, input logic stl,
                          input logic errs, input logic crc, input logic tmo,
                          input logic tgl);
      hs_ready = hs; nak_i = nak; stall_i = stl;
      errs_ready = errs; crc_err = crc; timeout_err = tmo; toggle_err = tgl;
      step();
      hs_ready = 1'b0; nak_i = 1'b0; stall_i = 1'b0;
      errs_ready = 1'b0; crc_err = 1'b0; timeout_err = 1'b0; toggle_err = 1'b0;
   endtask

   task automatic done_chk(input string tag, input int ch, input int st, input int rt);
      #1;
      check_eq({tag, "_dv"}, 32'(done_valid), 32'(1 << ch));
      check_eq({tag, "_st"}, 32'(done_status), 32'(st));
      check_eq({tag, "_rt"}, 32'(done_retries), 32'(rt));
      step();
   endtask

   task automatic wait_sof(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (sof_req) begin
            found = 1'b1;
            break;
         end
         step();
      end
      if (!found) check_eq(tag, 32'(sof_req), 1);
   endtask

   task automatic sof_pulse();
      sof_done = 1'b1;
      step();
      sof_done = 1'b0;
      #1;
   endtask

   initial begin
      logic [10:0] exp_f;
      rst_n = 1'b0; frame_en = 1'b0; req_valid = '0;
      tok_ready = 1'b0; sof_done = 1'b0;
      hs_ready = 1'b0; nak_i = 1'b0; stall_i = 1'b0;
      errs_ready = 1'b0; crc_err = 1'b0; timeout_err = 1'b0; toggle_err = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         req_pid[c*8 +: 8]  = pid_of(c);
         req_addr[c*7 +: 7] = addr_of(c);
         req_ep[c*4 +: 4]   = ep_of(c);
         req_toggle[c]      = tgl_of(c);
      end

      // Reset state
      repeat (3) @(posedge UHCI_clk);
      #3;
      check_eq("rst_tok_valid", 32'(tok_valid), 0);
      check_eq("rst_req_ready", 32'(req_ready), 0);
      check_eq("rst_done_valid", 32'(done_valid), 0);
      check_eq("rst_sof_req", 32'(sof_req), 0);
      check_eq("rst_frame_num", 32'(frame_num), 0);
      check_eq("rst_stat", 32'(stat_retries), 0);
      rst_n = 1'b1;
      step();

      // Channels 0 and 2 together, ptr=0: 2 wins, then 0; both ACK
      req_valid = 4'b0101;
      wait_grant("rr_first", 4'b0100);
      tok_phase("ack2", 2);
      respond(1, 0, 0, 0, 0, 0, 0);
      done_chk("ack2", 2, 0, 0);
      wait_grant("rr_second", 4'b0001);
      tok_phase("ack0", 0);
      respond(1, 0, 0, 0, 0, 0, 0);
      done_chk("ack0", 0, 0, 0);

      // Channel 1: four timeouts exhaust MAX_RETRY=3
      req_valid = 4'b0010;
      wait_grant("retry_gnt", 4'b0010);
      n_tok = 0;
      for (int k = 0; k < 4; k++) begin
         tok_phase("retry", 1);
         respond(0, 0, 0, 1, 0, 1, 0);
      end
      check_eq("retry_tok_cnt", 32'(n_tok), 4);
      done_chk("retry_err", 1, 3, 3);
      check_eq("stat_default", 32'(stat_retries), 0);

      // Channel 3: hs+crc together retries, then NAK without retry
      req_valid = 4'b1000;
      wait_grant("both_gnt", 4'b1000);
      tok_phase("both1", 3);
      respond(1, 0, 0, 1, 1, 0, 0);
      tok_phase("both2", 3);
      respond(1, 1, 0, 0, 0, 0, 0);
      done_chk("nak", 3, 1, 1);

      // Channel 0 STALL (stall beats nak)
      req_valid = 4'b0001;
      wait_grant("stall_gnt", 4'b0001);
      tok_phase("stall", 0);
      respond(1, 1, 1, 0, 0, 0, 0);
      done_chk("stall", 0, 2, 0);

      // Channel 2 toggle error, no retry even with crc
      req_valid = 4'b0100;
      wait_grant("tgl_gnt", 4'b0100);
      tok_phase("tgl", 2);
      respond(0, 0, 0, 1, 1, 0, 1);
      done_chk("tgl", 2, 4, 0);

      // Reset while in WAIT: outputs clear at once, no done pulse
      req_valid = 4'b0010;
      wait_grant("rstw_gnt", 4'b0010);
      tok_phase("rstw", 1);
      rst_n = 1'b0;
      #1;
      check_eq("rstw_tok_valid", 32'(tok_valid), 0);
      check_eq("rstw_tok_pid", 32'(tok_pid), 0);
      check_eq("rstw_done_valid", 32'(done_valid), 0);
      check_eq("rstw_req_ready", 32'(req_ready), 0);
      hs_ready = 1'b1;
      step();
      hs_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      check_eq("rstw_no_done", 32'(done_valid), 0);
      step();
      #1;
      check_eq("rstw_no_done2", 32'(done_valid), 0);
      req_valid = 4'b0100;
      wait_grant("post_rst_gnt", 4'b0100);
      tok_phase("post_rst", 2);
      respond(1, 0, 0, 0, 0, 0, 0);
      done_chk("post_rst", 2, 0, 0);

      // Guard window: request at counter 17 (limit 16) is held off; SOF first
      step();
      frame_en = 1'b1;
      repeat (17) @(posedge UHCI_clk);
      #2;
      req_valid = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("guard_hold", 32'(req_ready), 0);
         step();
      end
      wait_sof("guard_sof");
      check_eq("guard_frame0", 32'(frame_num), 0);
      sof_pulse();
      check_eq("guard_frame1", 32'(frame_num), 1);
      wait_grant("guard_gnt", 4'b0001);
      tok_phase("guard", 0);
      respond(1, 0, 0, 0, 0, 0, 0);
      done_chk("guard", 0, 0, 0);

      // 2048 SOFs: frame number wraps 2047 -> 0 and returns to its start
      exp_f = 11'd1;
      for (int k = 0; k < 2048; k++) begin
         wait_sof("sof_loop");
         if (exp_f >= 11'd2046 || exp_f <= 11'd1)
            check_eq("frame_pre", 32'(frame_num), 32'(exp_f));
         sof_pulse();
         exp_f = exp_f + 11'd1;
         if (exp_f >= 11'd2046 || exp_f <= 11'd1)
            check_eq("frame_post", 32'(frame_num), 32'(exp_f));
      end
      check_eq("frame_final", 32'(frame_num), 32'(exp_f));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uhci_xfer_sched.md
Name: uhci_xfer_sched

Overview:
- Multi-channel transaction scheduler between the UHCI controller and the SIE token/handshake interface.
- Generalises the single-requester host path to N_CH independent transfer channels, arbitrated round-robin.
- Owns the 1 ms frame timer, SOF issue and the 11-bit frame number.
- Retries CRC/timeout errors up to MAX_RETRY, then reports a one-hot completion status per channel.

Parameters:
- N_CH, 4: number of transfer request channels (2..8).
- MAX_RETRY, 3: maximum issues per transfer after the first on CRC/timeout errors (1..7).
- FRAME_CYCLES, 12000: UHCI_clk cycles per frame.
- GUARD_CYCLES, 600: end-of-frame window in which no new transfer is granted.
- CNT_W, $clog2(FRAME_CYCLES): frame counter width (derived).

Ports:
- UHCI_clk  in  1  clock
- rst_n  in  1  reset
- frame_en  in  1  enables the frame timer and SOF generation
- req_valid  in  N_CH  per-channel transfer request, held until req_ready
- req_pid  in  N_CH*8  token PID per channel
- req_addr  in  N_CH*7  device address per channel
- req_ep  in  N_CH*4  endpoint per channel
- req_toggle  in  N_CH  data toggle per channel
- req_ready  out  N_CH  one-cycle grant pulse, one-hot
- done_valid  out  N_CH  one-cycle completion pulse, one-hot
- done_status  out  3  valid with done_valid: 0 ACK, 1 NAK, 2 STALL, 3 ERR, 4 TOGGLE_ERR
- done_retries  out  3  retries used, valid with done_valid
- tok_valid  out  1  token request to SIE
- tok_pid  out  8  token PID
- tok_addr  out  7  device address
- tok_ep  out  4  endpoint
- tok_toggle  out  1  data toggle
- tok_ready  in  1  SIE accepted token
- sof_req  out  1  SOF request, held until sof_done
- frame_num  out  11  current frame number
- sof_done  in  1  SIE finished SOF
- hs_ready  in  1  handshake received
- nak_i  in  1  qualifies hs_ready
- stall_i  in  1  qualifies hs_ready
- errs_ready  in  1  error report strobe
- crc_err  in  1  qualifies errs_ready
- timeout_err  in  1  qualifies errs_ready
- toggle_err  in  1  qualifies errs_ready
- stat_retries  out  N_CH*8  see Optional Feature

Behaviour:
- Reset is asynchronous, active-low. All outputs, state, counters and frame_num are 0; the arbiter pointer is 0. Reset mid-transfer abandons the transfer with no done pulse.
- Frame timer:
  - While frame_en=1, counts 0..FRAME_CYCLES-1 and wraps. At wrap it sets sof_pending.
  - While frame_en=0, the counter is held at 0 and sof_pending is cleared.
- States are IDLE, SOF, ISSUE, WAIT, REPORT.
- IDLE:
  - sof_pending has priority: go to SOF.
  - Else, if any req_valid and counter < FRAME_CYCLES-GUARD_CYCLES: grant the first requesting channel at or after ptr+1 (mod N_CH).
  - On grant: pulse req_ready for that channel, latch its fields and channel index, clear the retry count, go to ISSUE, and set ptr to the granted channel.
- SOF:
  - sof_req=1 until sof_done.
  - On sof_done: frame_num increments (2047 wraps to 0), sof_pending clears, return to IDLE.
- ISSUE:
  - tok_* are driven from the latched fields with tok_valid=1; fields are stable while tok_valid is high.
  - On tok_ready: tok_valid drops the next cycle, go to WAIT.
- WAIT, on hs_ready:
  - stall_i gives STALL; else nak_i gives NAK; else ACK. Go to REPORT.
  - NAK is never retried.
- WAIT, on errs_ready:
  - toggle_err gives TOGGLE_ERR with no retry.
  - Otherwise (crc_err, timeout_err, or unqualified): if retry count < MAX_RETRY, increment it and return to ISSUE; else ERR.
- WAIT, simultaneous hs_ready and errs_ready: errs_ready wins.
- WAIT does not service SOF; a pending SOF waits until the transfer returns to IDLE.
- REPORT:
  - One cycle: done_valid[ch]=1 with done_status and done_retries, then IDLE.
  - A channel may re-request on the cycle after its done pulse.
- Latency: grant to tok_valid is 1 cycle. Latched response to done_valid is 1 cycle.

Optional Feature:
- Macro: UHCI_SCHED_STATS_EN.
- With the macro: stat_retries holds a per-channel 8-bit saturating (at 255) counter of retries, incremented on each retry; reset clears it.
- Without the macro: stat_retries is tied to 0 and no counter flops exist.

Decomposition:
- Package uhci_sched_pkg holds:
  - the state enum;
  - status codes ST_ACK=0, ST_NAK=1, ST_STALL=2, ST_ERR=3, ST_TOGGLE_ERR=4;
  - PID width 8, address width 7, endpoint width 4, frame width 11.
- Sub-module uhci_rr_arbiter (N_CH request vector in, ptr in, one-hot grant and index out), purely combinational.

Test Plan:
- Channels 0 and 2 request together with ptr=0: grants go 2 then 0; each gets ACK (hs_ready, no nak/stall): done_status=0, done_retries=0.
- Channel 1 receives errs_ready+timeout_err 4 times with MAX_RETRY=3: tok_valid issued 4 times, then done_status=3, done_retries=3.
- FRAME_CYCLES=100, GUARD_CYCLES=10, request raised at counter 92: no grant; SOF at wrap takes priority; frame_num goes 0 to 1 after sof_done; grant follows.
- frame_num preset path: run 2048 SOFs; frame_num returns 2047 to 0.
- hs_ready and errs_ready(crc) in the same cycle: treated as an error, so a retry reissues the token; hs_ready+nak_i gives done_status=1 with no retry.
- rst_n low while in WAIT: all outputs 0 within the same cycle, no done pulse; after release the next request is granted normally.
